// File: rtl/intra_pkg.sv
// intra_pkg: block-size encoding, size lookups and FSM states shared by the reconstruction stream.
package intra_pkg;

    typedef enum logic [1:0] {SZ_4 = 2'd0, SZ_8 = 2'd1, SZ_16 = 2'd2, SZ_RSV = 2'd3} blk_size_e;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    function automatic blk_size_e eff_size(logic [1:0] s);
        return s == SZ_RSV ? SZ_4 : blk_size_e'(s);
    endfunction

    function automatic logic [2:0] log2_n(blk_size_e s);
        return s == SZ_16 ? 3'd4 : s == SZ_8 ? 3'd3 : 3'd2;
    endfunction

    function automatic logic [4:0] n_of(blk_size_e s);
        return 5'd1 << log2_n(s);
    endfunction

endpackage

// File: rtl/recon_clip_lane.sv
// recon_clip_lane: one pixel of prediction plus signed residue, clipped to the unsigned sample range.
module recon_clip_lane #(
    parameter int BIT_DEPTH = 8
) (
    input  logic [BIT_DEPTH-1:0] pred,
    input  logic [BIT_DEPTH:0]   resid,
    output logic [BIT_DEPTH-1:0] pix,
    output logic                 clipped
);
    logic signed [BIT_DEPTH+1:0] sum;

    assign sum = $signed({2'b00, pred}) + $signed({resid[BIT_DEPTH], resid});
    // sign bit means below zero, the next bit means above full scale
    assign clipped = sum[BIT_DEPTH+1] | sum[BIT_DEPTH];
    assign pix = sum[BIT_DEPTH+1] ? '0 : sum[BIT_DEPTH] ? '1 : sum[BIT_DEPTH-1:0];
endmodule

// File: rtl/intra_recon_stream.sv
// intra_recon_stream: streaming pred+resid reconstruction with raster position tags,
// a 2-entry output buffer and saturating clip statistics.
module intra_recon_stream
    import intra_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int LANES     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [1:0]                     cfg_size,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [LANES*BIT_DEPTH-1:0]     in_pred,
    input  logic [LANES*(BIT_DEPTH+1)-1:0] in_resid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*BIT_DEPTH-1:0]     out_pix,
    output logic                           out_last,
    output logic [3:0]                     out_row,
    output logic [3:0]                     out_col,
    output logic [CNT_W-1:0]               clip_count,
    output logic                           cfg_err
);
    localparam int PW   = LANES * BIT_DEPTH;
    localparam int LG_L = $clog2(LANES);

    logic [PW-1:0]    pix;
    logic [LANES-1:0] clipped;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        recon_clip_lane #(.BIT_DEPTH(BIT_DEPTH)) u_lane (
            .pred   (in_pred[g*BIT_DEPTH +: BIT_DEPTH]),
            .resid  (in_resid[g*(BIT_DEPTH+1) +: BIT_DEPTH+1]),
            .pix    (pix[g*BIT_DEPTH +: BIT_DEPTH]),
            .clipped(clipped[g])
        );
    end

    state_e    state_q, state_d;
    blk_size_e size_q, size_d;
    logic [7:0] cnt_q, cnt_d, idx;
    logic [2:0] lg;
    logic [8:0] bpb;
    logic [3:0] row, col;
    logic       last, push, pop;
    logic [1:0] occ;

    assign in_ready  = reset & (occ != 2'd2);
    assign out_valid = occ != 2'd0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // block size is taken from cfg_size only on the first beat of a block
    always_comb begin
        size_d  = state_q == IDLE ? eff_size(cfg_size) : size_q;
        lg      = log2_n(size_d);
        bpb     = 9'd1 << ({lg, 1'b0} - 4'(LG_L));
        last    = {1'b0, cnt_q} == bpb - 9'd1;
        idx     = cnt_q << LG_L;
        row     = 4'(idx >> lg);
        col     = 4'(idx & {3'b000, n_of(size_d) - 5'd1});
        cnt_d   = last ? '0 : cnt_q + 8'd1;
        state_d = last ? IDLE : RUN;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            size_q  <= SZ_4;
            cnt_q   <= '0;
        end else if (push) begin
            state_q <= state_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
        end

    logic [PW-1:0] pix1;
    logic          last1;
    logic [3:0]    row1, col1;

    // head entry drives out_* directly; second entry only fills while the head is stalled
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            occ      <= '0;
            out_pix  <= '0;
            out_last <= 1'b0;
            out_row  <= '0;
            out_col  <= '0;
            pix1     <= '0;
            last1    <= 1'b0;
            row1     <= '0;
            col1     <= '0;
        end else begin
            occ <= occ + 2'(push) - 2'(pop);
            if (push && (occ == 2'd0 || pop))
                {out_pix, out_last, out_row, out_col} <= {pix, last, row, col};
            else if (pop && occ == 2'd2)
                {out_pix, out_last, out_row, out_col} <= {pix1, last1, row1, col1};
            if (push && occ == 2'd1 && !pop)
                {pix1, last1, row1, col1} <= {pix, last, row, col};
        end

    logic [4:0]     ncl;
    logic [CNT_W:0] csum;

    always_comb begin
        ncl = '0;
        for (int i = 0; i < LANES; i++) ncl = ncl + 5'(clipped[i]);
        csum = {1'b0, clip_count} + (CNT_W+1)'(ncl);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            clip_count <= '0;
            cfg_err    <= 1'b0;
        end else if (push) begin
            clip_count <= csum[CNT_W] ? '1 : csum[CNT_W-1:0];
            cfg_err    <= cfg_err | (state_q == IDLE && cfg_size == 2'd3);
        end
endmodule
